// File: rtl/score_display.sv
// Four-digit multiplexed score display: double-dabble binary-to-BCD converter feeding a scanned 7-segment driver.
// Optional build macro SCORE_DISPLAY_LZB_EN blanks leading zeros (digit 0 always shown).
module score_display #(
  parameter int REFRESH_DIV = 100000,
  parameter int BLINK_DIV   = 250
) (
  input  logic       clk,
  input  logic       clr_n,
  input  logic [9:0] current_score,
  input  logic [9:0] highest_score,
  input  logic       game_state,
  output logic [6:0] seg,
  output logic [3:0] an,
  output logic       dp,
  output logic       busy,
  output logic [1:0] state_dbg
);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_SHIFT = 2'd1;
  localparam logic [1:0] S_DONE  = 2'd2;

  localparam int RW = $clog2(REFRESH_DIV);
  localparam int BW = $clog2(BLINK_DIV + 1);

  logic [1:0]    rst_sync;
  logic          rst_n;
  logic [9:0]    sel_q;
  logic          gs_q;
  logic [1:0]    state;
  logic [3:0]    iter;
  logic [25:0]   shreg;
  logic [9:0]    val_q;
  logic [9:0]    last_q;
  logic [15:0]   digit_q;
  logic [RW-1:0] ref_cnt;
  logic [1:0]    digit_idx;
  logic [BW-1:0] blink_cnt;
  logic          blink_on;
  logic          wrap;
  logic [3:0]    cur_digit;
  logic          digit_shown;
  logic          lit;

  // Assertion is immediate; release reaches the core only after two clean edges.
  always_ff @(posedge clk or negedge clr_n) begin
    if (!clr_n) rst_sync <= 2'b00;
    else        rst_sync <= {rst_sync[0], 1'b1};
  end
  assign rst_n = rst_sync[1];

  function automatic logic [25:0] dd_step(input logic [25:0] r);
    logic [25:0] a;
    a = r;
    for (int i = 0; i < 4; i++) begin
      if (a[10+4*i +: 4] >= 4'd5) a[10+4*i +: 4] = a[10+4*i +: 4] + 4'd3;
    end
    return {a[24:0], 1'b0};
  endfunction

  function automatic logic [6:0] seg_decode(input logic [3:0] d);
    logic [6:0] s;
    case (d)
      4'd0:    s = 7'b1000000;
      4'd1:    s = 7'b1111001;
      4'd2:    s = 7'b0100100;
      4'd3:    s = 7'b0110000;
      4'd4:    s = 7'b0011001;
      4'd5:    s = 7'b0010010;
      4'd6:    s = 7'b0000010;
      4'd7:    s = 7'b1111000;
      4'd8:    s = 7'b0000000;
      4'd9:    s = 7'b0010000;
      default: s = 7'b1111111;
    endcase
    return s;
  endfunction

  // Converter: the input is latched on entry to SHIFT, so digit_q only ever sees whole results.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sel_q   <= '0;
      gs_q    <= 1'b0;
      state   <= S_IDLE;
      iter    <= '0;
      shreg   <= '0;
      val_q   <= '0;
      last_q  <= '0;
      digit_q <= '0;
    end else begin
      sel_q <= game_state ? current_score : highest_score;
      gs_q  <= game_state;
      case (state)
        S_IDLE: begin
          if (sel_q != last_q) begin
            state <= S_SHIFT;
            shreg <= {16'd0, sel_q};
            val_q <= sel_q;
            iter  <= '0;
          end
        end
        S_SHIFT: begin
          shreg <= dd_step(shreg);
          iter  <= iter + 4'd1;
          if (iter == 4'd9) state <= S_DONE;
        end
        S_DONE: begin
          digit_q <= shreg[25:10];
          last_q  <= val_q;
          state   <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  assign busy      = (state != S_IDLE);
  assign state_dbg = state;

  assign wrap = (ref_cnt == RW'(REFRESH_DIV - 1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ref_cnt   <= '0;
      digit_idx <= '0;
      blink_cnt <= '0;
      blink_on  <= 1'b1;
    end else begin
      if (wrap) begin
        ref_cnt   <= '0;
        digit_idx <= digit_idx + 2'd1;
      end else begin
        ref_cnt <= ref_cnt + RW'(1);
      end
      // Blink only runs while the game is over; a running game pins the display on.
      if (gs_q) begin
        blink_cnt <= '0;
        blink_on  <= 1'b1;
      end else if (wrap) begin
        if (blink_cnt == BW'(BLINK_DIV - 1)) begin
          blink_cnt <= '0;
          blink_on  <= ~blink_on;
        end else begin
          blink_cnt <= blink_cnt + BW'(1);
        end
      end
    end
  end

  assign cur_digit = digit_q[{digit_idx, 2'b00} +: 4];

  always_comb begin
`ifdef SCORE_DISPLAY_LZB_EN
    case (digit_idx)
      2'd3:    digit_shown = (digit_q[15:12] != 4'd0);
      2'd2:    digit_shown = (digit_q[15:8] != 8'd0);
      2'd1:    digit_shown = (digit_q[15:4] != 12'd0);
      default: digit_shown = 1'b1;
    endcase
`else
    digit_shown = 1'b1;
`endif
  end

  assign lit = blink_on && digit_shown;
  assign an  = lit ? ~(4'b0001 << digit_idx) : 4'b1111;
  assign seg = lit ? seg_decode(cur_digit) : 7'b1111111;
  assign dp  = 1'b1;

endmodule

// File: tb/tb_score_display.sv
// Bench for score_display: decimal-arithmetic reference model checked every cycle, plus literal scenario checks.
module tb_score_display;
  localparam int RD = 4;
  localparam int BD = 2;

  logic       clk = 1'b0;
  logic       clr_n = 1'b0;
  logic [9:0] current_score = '0;
  logic [9:0] highest_score = '0;
  logic       game_state = 1'b1;
  logic [6:0] seg;
  logic [3:0] an;
  logic       dp;
  logic       busy;
  logic [1:0] state_dbg;

  score_display #(.REFRESH_DIV(RD), .BLINK_DIV(BD)) dut (
    .clk(clk), .clr_n(clr_n), .current_score(current_score),
    .highest_score(highest_score), .game_state(game_state),
    .seg(seg), .an(an), .dp(dp), .busy(busy), .state_dbg(state_dbg)
  );

  initial forever #5 clk = ~clk;

  int n_checks = 0;
  int n_fail = 0;
  bit compare_en = 1'b0;

  logic [6:0] seg_tbl[10] = '{7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000, 7'b0011001,
                              7'b0010010, 7'b0000010, 7'b1111000, 7'b0000000, 7'b0010000};
  int p10[4] = '{1, 10, 100, 1000};

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: conversions as an 11-cycle delay line of decimal values,
  // scan position and blink phase derived from elapsed cycles and slot counts.
  int         m_hold = 2;
  logic [9:0] m_sel = '0;
  logic       m_gs = 1'b0;
  int         m_cnt = 0;
  logic [9:0] m_last = '0;
  int         m_dig = 0;
  int         m_ticks = 0;
  int         m_w = 0;
  logic [9:0] exp_q[$];

  task automatic model_reset();
    m_hold = 2; m_sel = '0; m_gs = 1'b0; m_cnt = 0; m_last = '0;
    m_dig = 0; m_ticks = 0; m_w = 0;
    exp_q.delete();
  endtask

  task automatic model_step();
    logic [9:0] old_sel;
    logic       old_gs;
    bit         wr;
    old_sel = m_sel;
    old_gs  = m_gs;
    m_sel = game_state ? current_score : highest_score;
    m_gs  = game_state;
    if (m_cnt == 0) begin
      if (old_sel != m_last) begin
        m_cnt = 11;
        exp_q.push_back(old_sel);
      end
    end else begin
      m_cnt--;
      if (m_cnt == 0) begin
        m_last = exp_q.pop_front();
        m_dig  = int'(m_last);
      end
    end
    wr = ((m_ticks % RD) == RD - 1);
    m_ticks++;
    if (old_gs) m_w = 0;
    else if (wr) m_w++;
  endtask

  always @(posedge clk) begin
    if (!clr_n) model_reset();
    else if (m_hold > 0) m_hold--;
    else model_step();
  end

  always @(negedge clr_n) model_reset();

  task automatic cmp_outputs();
    int idx, d;
    bit shown, on, lt;
    logic [3:0] ea;
    logic [6:0] es;
    idx = (m_ticks / RD) % 4;
    d   = (m_dig / p10[idx]) % 10;
`ifdef SCORE_DISPLAY_LZB_EN
    shown = (idx == 0) || (m_dig >= p10[idx]);
`else
    shown = 1'b1;
`endif
    on = ((m_w / BD) % 2) == 0;
    lt = on && shown;
    ea = lt ? ~(4'b0001 << idx) : 4'b1111;
    es = lt ? seg_tbl[d] : 7'b1111111;
    check("an", an, ea);
    check("seg", seg, es);
    check("busy", busy, (m_cnt != 0));
    check("dp", dp, 1'b1);
  endtask

  initial begin
    forever begin
      @(negedge clk);
      #1;
      if (compare_en) cmp_outputs();
    end
  end

  task automatic wait_an(input logic [3:0] t, input string name);
    int k;
    k = 0;
    while (an !== t && k < 64) begin
      @(negedge clk); #1; k++;
    end
    if (an !== t) check(name, an, t);
  endtask

  initial begin
    int first_busy, busy_cnt, dark, low_hi;
    logic [3:0] seen;
    logic [3:0] scan_exp[12];
    scan_exp = '{4'b1101, 4'b1101, 4'b1101, 4'b1011, 4'b1011, 4'b1011, 4'b1011,
                 4'b0111, 4'b0111, 4'b0111, 4'b0111, 4'b1110};

    // Reset state
    repeat (3) @(negedge clk);
    compare_en = 1'b1;
    #1;
    check("rst_an", an, 4'b1110);
    check("rst_seg", seg, 7'b1000000);
    check("rst_busy", busy, 1'b0);
    @(negedge clk);
    clr_n = 1'b1;

    // Scan order with value 0
`ifndef SCORE_DISPLAY_LZB_EN
    wait_an(4'b1101, "scan_start");
    for (int i = 0; i < 12; i++) begin
      @(negedge clk); #1;
      check("scan_seq", an, scan_exp[i]);
    end
`else
    for (int i = 0; i < 16; i++) begin
      @(negedge clk); #1;
      check("scan_lzb0", an[3:1], 3'b111);
    end
`endif

    // 0 -> 1023: busy window and latency
    @(negedge clk);
    current_score = 10'd1023;
    first_busy = 0; busy_cnt = 0;
    for (int i = 1; i <= 30; i++) begin
      @(negedge clk); #1;
      if (busy) begin
        busy_cnt++;
        if (first_busy == 0) first_busy = i;
      end
    end
    check("busy_first", first_busy, 2);
    check("busy_len", busy_cnt, 11);
    check("model_1023", m_dig, 1023);
    wait_an(4'b0111, "find_d3");
    check("seg_d3_1023", seg, 7'b1111001);

    // 57 then 58 mid-conversion
    @(negedge clk);
    current_score = 10'd57;
    repeat (3) @(negedge clk);
    current_score = 10'd58;
    repeat (40) @(negedge clk);
    #1;
    check("model_58", m_dig, 58);
    wait_an(4'b1110, "find_d0_58");
    check("seg_d0_58", seg, 7'b0000000);
    wait_an(4'b1101, "find_d1_58");
    check("seg_d1_58", seg, 7'b0010010);

    // Reset in the middle of a conversion
    @(negedge clk);
    current_score = 10'd500;
    repeat (6) @(negedge clk);
    check("busy_pre_rst", busy, 1'b1);
    clr_n = 1'b0;
    #1;
    check("rst_mid_busy", busy, 1'b0);
    check("rst_mid_an", an, 4'b1110);
    repeat (2) @(negedge clk);
    clr_n = 1'b1;
    repeat (20) @(negedge clk);
    #1;
    check("model_500", m_dig, 500);
    wait_an(4'b1011, "find_d2_500");
    check("seg_d2_500", seg, 7'b0010010);
    wait_an(4'b1110, "find_d0_500");
    check("seg_d0_500", seg, 7'b1000000);

    // Leading-zero handling with value 7
    @(negedge clk);
    current_score = 10'd7;
    repeat (20) @(negedge clk);
    low_hi = 0; seen = 4'b0000;
    for (int i = 0; i < 32; i++) begin
      @(negedge clk); #1;
      if (an[3:1] != 3'b111) low_hi++;
      seen = seen | ~an;
    end
`ifdef SCORE_DISPLAY_LZB_EN
    check("lzb_hi_dark", low_hi, 0);
`else
    check("all_scan", seen, 4'b1111);
`endif
    wait_an(4'b1110, "find_d0_7");
    check("seg_d0_7", seg, 7'b1111000);

    // Game over: blink on highest score
    @(negedge clk);
    game_state = 1'b0;
    highest_score = 10'd42;
    repeat (30) @(negedge clk);
    #1;
    check("model_42", m_dig, 42);
    dark = 0;
    for (int i = 0; i < 64; i++) begin
      @(negedge clk); #1;
      if (an == 4'b1111) dark++;
    end
`ifdef SCORE_DISPLAY_LZB_EN
    check("blink_dark", (dark >= 32), 1'b1);
`else
    check("blink_dark", dark, 32);
`endif

    // Randomized traffic against the model
    for (int it = 0; it < 300; it++) begin
      @(negedge clk);
      if ($urandom_range(0, 39) == 0) begin
        clr_n = 1'b0;
        repeat ($urandom_range(1, 3)) @(negedge clk);
        clr_n = 1'b1;
      end
      game_state = ($urandom_range(0, 3) != 0);
      current_score = ($urandom_range(0, 1) == 1) ? 10'($urandom_range(0, 1023))
                                                  : 10'($urandom_range(0, 120));
      if ($urandom_range(0, 3) == 0) highest_score = 10'($urandom_range(0, 1023));
      repeat ($urandom_range(0, 20)) @(negedge clk);
    end
    repeat (40) @(negedge clk);
    #2;

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
